// File: rtl/apb_cmd_master.sv
// Command-stream to APB3 master: one transfer in flight, SETUP/ACCESS sequencing,
// registered valid/ready response, optional abort when the slave stalls in ACCESS.
module apb_cmd_master #(
  parameter int PADDR_SIZE = 12,
  parameter int PDATA_SIZE = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [PADDR_SIZE-1:0] cmd_addr,
  input  logic [PDATA_SIZE-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [PDATA_SIZE-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic                  MST_PSEL,
  output logic                  MST_PENABLE,
  output logic [PADDR_SIZE-1:0] MST_PADDR,
  output logic                  MST_PWRITE,
  output logic [PDATA_SIZE-1:0] MST_PWDATA,
  input  logic [PDATA_SIZE-1:0] MST_PRDATA,
  input  logic                  MST_PREADY,
  input  logic                  MST_PSLVERR
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW:0] TO_LIM = (CW+1)'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t                  state_q;
  logic [CW-1:0]           cnt_q;
  logic                    cmd_ready_q;
  logic                    psel_q;
  logic                    penable_q;
  logic [PADDR_SIZE-1:0]   paddr_q;
  logic                    pwrite_q;
  logic [PDATA_SIZE-1:0]   pwdata_q;
  logic                    rsp_valid_q;
  logic [PDATA_SIZE-1:0]   rsp_rdata_q;
  logic                    rsp_err_q;
  logic                    rsp_timeout_q;

  logic [CW:0]             cnt_inc_d;
  logic                    to_hit_d;

  // The current stalled cycle is the one that reaches the limit when cnt_q+1 == TIMEOUT.
  assign cnt_inc_d = {1'b0, cnt_q} + {{CW{1'b0}}, 1'b1};
  assign to_hit_d  = (TIMEOUT != 0) && (cnt_inc_d == TO_LIM);

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      cmd_ready_q   <= 1'b0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      paddr_q       <= '0;
      pwrite_q      <= 1'b0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid && cmd_ready_q) begin
            state_q     <= SETUP;
            cmd_ready_q <= 1'b0;
            psel_q      <= 1'b1;
            paddr_q     <= cmd_addr;
            pwrite_q    <= cmd_write;
            pwdata_q    <= cmd_wdata;
          end else begin
            cmd_ready_q <= 1'b1;
          end
        end
        SETUP: begin
          state_q   <= ACCESS;
          penable_q <= 1'b1;
          cnt_q     <= '0;
        end
        ACCESS: begin
          if (MST_PREADY) begin
            state_q       <= RESP;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_err_q     <= MST_PSLVERR;
            rsp_timeout_q <= 1'b0;
            rsp_rdata_q   <= pwrite_q ? '0 : MST_PRDATA;
          end else if (to_hit_d) begin
            state_q       <= RESP;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_err_q     <= 1'b1;
            rsp_timeout_q <= 1'b1;
            rsp_rdata_q   <= '0;
          end else if (cnt_q != '1) begin
            // Saturate so TIMEOUT=0 never wraps into a spurious match.
            cnt_q <= cnt_inc_d[CW-1:0];
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign MST_PSEL    = psel_q;
  assign MST_PENABLE = penable_q;
  assign MST_PADDR   = paddr_q;
  assign MST_PWRITE  = pwrite_q;
  assign MST_PWDATA  = pwdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed bench for apb_cmd_master with TIMEOUT=4; inputs change and outputs are
// sampled 1ns after each rising edge.
module tb_apb_cmd_master;

  logic        PCLK = 1'b0;
  logic        PRESET = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [11:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic        MST_PSEL;
  logic        MST_PENABLE;
  logic [11:0] MST_PADDR;
  logic        MST_PWRITE;
  logic [31:0] MST_PWDATA;
  logic [31:0] MST_PRDATA = '0;
  logic        MST_PREADY = 1'b0;
  logic        MST_PSLVERR = 1'b0;

  int errs = 0;
  int checks = 0;

  apb_cmd_master #(.PADDR_SIZE(12), .PDATA_SIZE(32), .TIMEOUT(4)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .MST_PSEL(MST_PSEL), .MST_PENABLE(MST_PENABLE), .MST_PADDR(MST_PADDR),
    .MST_PWRITE(MST_PWRITE), .MST_PWDATA(MST_PWDATA), .MST_PRDATA(MST_PRDATA),
    .MST_PREADY(MST_PREADY), .MST_PSLVERR(MST_PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  // {cmd_ready, PSEL, PENABLE, rsp_valid, rsp_err, rsp_timeout}
  logic [5:0] st;
  assign st = {cmd_ready, MST_PSEL, MST_PENABLE, rsp_valid, rsp_err, rsp_timeout};

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic test_reset();
    PRESET = 1'b1;
    tick(); tick();
    checks++;
    if ({cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, MST_PSEL, MST_PENABLE,
         MST_PADDR, MST_PWRITE, MST_PWDATA} !== 83'd0) begin
      errs++; $display("FAIL reset_outputs: some output nonzero, st=%b paddr=%h", st, MST_PADDR);
    end
    PRESET = 1'b0;
    tick();
    checks++;
    if (st !== 6'b100000) begin errs++; $display("FAIL reset_release: st=%b exp=100000", st); end
  endtask

  task automatic test_write();
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 12'h004; cmd_wdata = 32'hA5A5_0001;
    MST_PREADY = 1'b1; MST_PRDATA = 32'hBAD0_BAD0;
    tick();
    cmd_valid = 1'b0; cmd_addr = 12'hFFF; cmd_wdata = 32'h0;
    checks++;
    if ({st, MST_PADDR, MST_PWRITE, MST_PWDATA} !== {6'b010000, 12'h004, 1'b1, 32'hA5A5_0001}) begin
      errs++; $display("FAIL wr_setup: st=%b addr=%h w=%b wd=%h exp 010000/004/1/a5a50001",
                       st, MST_PADDR, MST_PWRITE, MST_PWDATA);
    end
    tick();
    checks++;
    if ({st, MST_PADDR, MST_PWDATA} !== {6'b011000, 12'h004, 32'hA5A5_0001}) begin
      errs++; $display("FAIL wr_access: st=%b addr=%h wd=%h exp 011000/004/a5a50001",
                       st, MST_PADDR, MST_PWDATA);
    end
    tick();
    checks++;
    if ({st, rsp_rdata} !== {6'b000100, 32'h0}) begin
      errs++; $display("FAIL wr_resp: st=%b rdata=%h exp 000100/0", st, rsp_rdata);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checks++;
    if ({st, MST_PADDR, MST_PWRITE} !== {6'b100000, 12'h004, 1'b1}) begin
      errs++; $display("FAIL wr_done: st=%b addr=%h w=%b exp 100000/004/1", st, MST_PADDR, MST_PWRITE);
    end
  endtask

  // Ready arrives on the 4th ACCESS cycle, the same cycle the timeout limit would fire.
  task automatic test_read_wait();
    int acc = 0;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h008;
    MST_PREADY = 1'b0; MST_PRDATA = 32'hDEAD_BEEF;
    tick();
    cmd_valid = 1'b0;
    checks++;
    if ({st, MST_PADDR, MST_PWRITE} !== {6'b010000, 12'h008, 1'b0}) begin
      errs++; $display("FAIL rd_setup: st=%b addr=%h w=%b", st, MST_PADDR, MST_PWRITE);
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      if (st == 6'b011000) acc++;
      tick();
    end
    MST_PREADY = 1'b1; MST_PRDATA = 32'h0000_00C3;
    if (st == 6'b011000) acc++;
    tick();
    MST_PREADY = 1'b0; MST_PRDATA = 32'h5555_5555;
    checks++;
    if (acc !== 4) begin errs++; $display("FAIL rd_access_cycles: got %0d exp 4", acc); end
    checks++;
    if ({st, rsp_rdata} !== {6'b000100, 32'h0000_00C3}) begin
      errs++; $display("FAIL rd_resp: st=%b rdata=%h exp 000100/000000c3", st, rsp_rdata);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checks++;
    if ({st, rsp_rdata} !== {6'b100000, 32'h0000_00C3}) begin
      errs++; $display("FAIL rd_fields_hold: st=%b rdata=%h exp 100000/000000c3", st, rsp_rdata);
    end
  endtask

  task automatic test_slverr();
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h00C;
    MST_PREADY = 1'b1; MST_PSLVERR = 1'b1; MST_PRDATA = 32'h1234_5678;
    tick();
    cmd_valid = 1'b0;
    tick(); tick();
    MST_PSLVERR = 1'b0;
    checks++;
    if ({st, rsp_rdata} !== {6'b000110, 32'h1234_5678}) begin
      errs++; $display("FAIL slverr_resp: st=%b rdata=%h exp 000110/12345678", st, rsp_rdata);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_timeout();
    int acc = 0;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h010;
    MST_PREADY = 1'b0; MST_PRDATA = 32'hFFFF_FFFF;
    tick();
    cmd_valid = 1'b0;
    tick();
    for (int i = 0; i < 6 && MST_PENABLE; i++) begin
      acc++;
      tick();
    end
    checks++;
    if (acc !== 4) begin errs++; $display("FAIL to_access_cycles: got %0d exp 4", acc); end
    checks++;
    if ({st, rsp_rdata} !== {6'b000111, 32'h0}) begin
      errs++; $display("FAIL to_resp: st=%b rdata=%h exp 000111/0", st, rsp_rdata);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checks++;
    if (st !== 6'b100011) begin errs++; $display("FAIL to_done: st=%b exp 100011", st); end
  endtask

  task automatic test_back_to_back();
    int bad = 0;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 12'h020; cmd_wdata = 32'h0000_0011;
    MST_PREADY = 1'b1; MST_PRDATA = 32'h0;
    tick();
    cmd_addr = 12'h3FC; cmd_wdata = 32'h0000_0022;
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      if ({st, MST_PADDR, MST_PWDATA} !== {6'b000100, 12'h020, 32'h0000_0011}) bad++;
      tick();
    end
    checks++;
    if (bad !== 0) begin errs++; $display("FAIL stall_stable: bad cycles=%0d exp 0", bad); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checks++;
    if (st !== 6'b100000) begin errs++; $display("FAIL stall_release: st=%b exp 100000", st); end
    tick();
    cmd_valid = 1'b0;
    checks++;
    if ({st, MST_PADDR, MST_PWDATA} !== {6'b010000, 12'h3FC, 32'h0000_0022}) begin
      errs++; $display("FAIL b2b_setup: st=%b addr=%h wd=%h exp 010000/3fc/00000022",
                       st, MST_PADDR, MST_PWDATA);
    end
    tick(); tick();
    checks++;
    if (st !== 6'b000100) begin errs++; $display("FAIL b2b_resp: st=%b exp 000100", st); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 12'h044; cmd_wdata = 32'hCAFE_F00D;
    MST_PREADY = 1'b0;
    tick();
    cmd_valid = 1'b0;
    tick();
    checks++;
    if (st !== 6'b011000) begin errs++; $display("FAIL mid_access: st=%b exp 011000", st); end
    PRESET = 1'b1;
    tick();
    checks++;
    if ({st, MST_PADDR, MST_PWDATA} !== {6'b000000, 12'h0, 32'h0}) begin
      errs++; $display("FAIL mid_reset: st=%b addr=%h wd=%h exp all 0", st, MST_PADDR, MST_PWDATA);
    end
    PRESET = 1'b0;
    tick();
    checks++;
    if (st !== 6'b100000) begin errs++; $display("FAIL mid_release: st=%b exp 100000", st); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write();
    test_read_wait();
    test_slverr();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
